// File: rtl/bus_off_rcvr_ctrl.sv
// Bus-off recovery sequencer.
// While the node is bus-off, this block counts runs of consecutive recessive
// bits. Once enough complete runs have been seen, and the host permits it,
// it pulses init_err_st to the error/overload frame generator. It then waits
// for bus_off_sts to drop. If bus_off_sts does not drop in time, it re-issues
// the pulse.
module bus_off_rcvr_ctrl #(
  parameter int RCSV_LEN = 11,   // recessive bits per completed sequence
  parameter int SEQ_REQ  = 128,  // completed sequences required before recovery
  parameter int SEQ_W    = 8,    // width of sequence counter (holds SEQ_REQ)
  parameter int CLR_TMO  = 7     // cycles allowed for bus_off_sts to drop
) (
  input  logic             i_clk,
  input  logic             i_g_rst,
  input  logic             i_bus_off_sts,
  input  logic             i_sampled_bit,
  input  logic             i_smpl_en,
  input  logic             i_auto_rcvr_en,
  input  logic             i_rcvr_req,
  output logic             o_init_err_st,
  output logic             o_rcvr_busy,
  output logic             o_rcvr_done,
  output logic             o_rcvr_retry,
  output logic [SEQ_W-1:0] o_seq_cnt,
  output logic [3:0]       o_rcsv_cnt
);

  localparam int TMR_W = $clog2(CLR_TMO + 1);

  // Last legal value of each counter before it rolls over or triggers.
  localparam logic [3:0]       RCSV_LAST = 4'(RCSV_LEN - 1);
  localparam logic [SEQ_W-1:0] SEQ_LAST  = SEQ_W'(SEQ_REQ - 1);
  localparam logic [SEQ_W-1:0] SEQ_FULL  = SEQ_W'(SEQ_REQ);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLR_TMO - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_REQ   = 3'd1,
    ST_COUNT      = 3'd2,
    ST_INIT_PULSE = 3'd3,
    ST_WAIT_CLR   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_rcsv_cnt;
  logic [3:0]       w_rcsv_nxt;
  logic [SEQ_W-1:0] r_seq_cnt;
  logic [SEQ_W-1:0] w_seq_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic             r_auto_d;
  logic             w_auto_rise;
  logic             r_init_err_st;
  logic             w_init_nxt;
  logic             r_rcvr_busy;
  logic             w_busy_nxt;
  logic             r_rcvr_done;
  logic             w_done_nxt;
  logic             r_rcvr_retry;
  logic             w_retry_nxt;

  // auto_rcvr_en is edge-sensitive only while waiting for a host request.
  assign w_auto_rise = i_auto_rcvr_en & ~r_auto_d;

  // Next-state, counter and output-pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_rcsv_nxt  = r_rcsv_cnt;
    w_seq_nxt   = r_seq_cnt;
    w_tmr_nxt   = r_tmr;
    w_done_nxt  = 1'b0;
    w_retry_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_rcsv_nxt = 4'd0;
        w_seq_nxt  = '0;
        w_tmr_nxt  = '0;
        if (i_bus_off_sts) begin
          if (i_auto_rcvr_en) begin
            w_state_nxt = ST_COUNT;
          end else begin
            w_state_nxt = ST_WAIT_REQ;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_WAIT_REQ: begin
        w_rcsv_nxt = 4'd0;
        w_seq_nxt  = '0;
        w_tmr_nxt  = '0;
        if (!i_bus_off_sts) begin
          w_state_nxt = ST_IDLE;
        end else if (i_rcvr_req || w_auto_rise) begin
          w_state_nxt = ST_COUNT;
        end else begin
          w_state_nxt = ST_WAIT_REQ;
        end
      end

      ST_COUNT: begin
        // An external clear beats a coincident bit strobe.
        if (!i_bus_off_sts) begin
          w_state_nxt = ST_IDLE;
          w_rcsv_nxt  = 4'd0;
          w_seq_nxt   = '0;
        end else if (i_smpl_en) begin
          if (!i_sampled_bit) begin
            w_rcsv_nxt = 4'd0;
          end else if (r_rcsv_cnt < RCSV_LAST) begin
            w_rcsv_nxt = r_rcsv_cnt + 4'd1;
          end else begin
            // The run is complete. The next run starts from zero, so runs never overlap.
            w_rcsv_nxt = 4'd0;
            if (r_seq_cnt >= SEQ_LAST) begin
              w_seq_nxt   = SEQ_FULL;
              w_state_nxt = ST_INIT_PULSE;
            end else begin
              w_seq_nxt = r_seq_cnt + SEQ_W'(1);
            end
          end
        end else begin
          w_state_nxt = ST_COUNT;
        end
      end

      ST_INIT_PULSE: begin
        w_state_nxt = ST_WAIT_CLR;
        w_rcsv_nxt  = 4'd0;
        w_seq_nxt   = '0;
        w_tmr_nxt   = '0;
      end

      ST_WAIT_CLR: begin
        if (!i_bus_off_sts) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_tmr_nxt   = '0;
        end else if (r_tmr >= TMR_LAST) begin
          w_state_nxt = ST_INIT_PULSE;
          w_retry_nxt = 1'b1;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_rcsv_nxt  = 4'd0;
        w_seq_nxt   = '0;
        w_tmr_nxt   = '0;
      end
    endcase

    // Outputs are decoded from the next state, so the registers reflect the state on entry.
    w_init_nxt = (w_state_nxt == ST_INIT_PULSE);
    w_busy_nxt = (w_state_nxt == ST_COUNT) || (w_state_nxt == ST_INIT_PULSE) ||
                 (w_state_nxt == ST_WAIT_CLR);
  end

  // State, counter and registered-output update with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_g_rst) begin
      r_state       <= ST_IDLE;
      r_rcsv_cnt    <= 4'd0;
      r_seq_cnt     <= '0;
      r_tmr         <= '0;
      r_auto_d      <= 1'b0;
      r_init_err_st <= 1'b0;
      r_rcvr_busy   <= 1'b0;
      r_rcvr_done   <= 1'b0;
      r_rcvr_retry  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rcsv_cnt    <= w_rcsv_nxt;
      r_seq_cnt     <= w_seq_nxt;
      r_tmr         <= w_tmr_nxt;
      r_auto_d      <= i_auto_rcvr_en;
      r_init_err_st <= w_init_nxt;
      r_rcvr_busy   <= w_busy_nxt;
      r_rcvr_done   <= w_done_nxt;
      r_rcvr_retry  <= w_retry_nxt;
    end
  end

  assign o_init_err_st = r_init_err_st;
  assign o_rcvr_busy   = r_rcvr_busy;
  assign o_rcvr_done   = r_rcvr_done;
  assign o_rcvr_retry  = r_rcvr_retry;
  assign o_seq_cnt     = r_seq_cnt;
  assign o_rcsv_cnt    = r_rcsv_cnt;

endmodule

// File: tb/tb_bus_off_rcvr_ctrl.sv
// Directed bench for bus_off_rcvr_ctrl.
// The error/overload frame generator is modelled as 2 sync flops plus 1
// status flop. The model drops bus_off_sts 3 cycles after it sees
// init_err_st, when clearing is enabled.
module tb_bus_off_rcvr_ctrl;

  logic       clk = 1'b0;
  logic       g_rst = 1'b1;
  logic       bo_host = 1'b0;
  logic       sampled_bit = 1'b0;
  logic       smpl_en = 1'b0;
  logic       auto_en = 1'b0;
  logic       rcvr_req = 1'b0;
  logic       bus_off_sts;
  logic       init_err_st;
  logic       rcvr_busy;
  logic       rcvr_done;
  logic       rcvr_retry;
  logic [7:0] seq_cnt;
  logic [3:0] rcsv_cnt;

  // Generator model state.
  logic m_sync1 = 1'b0;
  logic m_sync2 = 1'b0;
  logic m_cleared = 1'b0;
  logic m_clr_en = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int n_init = 0;
  int cyc;
  int n_ext;
  int n_cnt;

  always #5 clk = ~clk;

  bus_off_rcvr_ctrl dut (
    .i_clk          (clk),
    .i_g_rst        (g_rst),
    .i_bus_off_sts  (bus_off_sts),
    .i_sampled_bit  (sampled_bit),
    .i_smpl_en      (smpl_en),
    .i_auto_rcvr_en (auto_en),
    .i_rcvr_req     (rcvr_req),
    .o_init_err_st  (init_err_st),
    .o_rcvr_busy    (rcvr_busy),
    .o_rcvr_done    (rcvr_done),
    .o_rcvr_retry   (rcvr_retry),
    .o_seq_cnt      (seq_cnt),
    .o_rcsv_cnt     (rcsv_cnt)
  );

  // bus_off_sts is high while the host holds the node bus-off, until the generator clears it.
  assign bus_off_sts = bo_host & ~m_cleared;

  // Generator: init_err_st passes through two sync flops, then the status flop clears bus-off.
  always @(posedge clk) begin
    m_sync1 <= init_err_st;
    m_sync2 <= m_sync1;
    if (!bo_host) m_cleared <= 1'b0;
    else if (m_sync2 && m_clr_en) m_cleared <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    g_rst = 1'b1; bo_host = 1'b0; smpl_en = 1'b0; sampled_bit = 1'b0;
    auto_en = 1'b0; rcvr_req = 1'b0; m_clr_en = 1'b1;
    tick(); tick();
    g_rst = 1'b0;
    tick();
  endtask

  // Each bit takes one strobe cycle followed by one idle cycle. Every init_err_st seen is counted.
  task automatic send_bits(input int n, input logic b);
    for (int i = 0; i < n; i++) begin
      sampled_bit = b; smpl_en = 1'b1;
      tick();
      if (init_err_st) n_init++;
      smpl_en = 1'b0;
      tick();
      if (init_err_st) n_init++;
    end
  endtask

  // Strobe the bit that completes the final run. init_err_st is then visible right after this edge.
  task automatic send_last_bit();
    sampled_bit = 1'b1; smpl_en = 1'b1;
    tick();
    smpl_en = 1'b0;
  endtask

  // Return how many cycles rcvr_done takes to appear, or -1 if it never does. Also count other pulses.
  task automatic wait_done(output int c_out, output int ext_out);
    c_out = -1; ext_out = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (init_err_st || rcvr_retry) ext_out++;
      if (rcvr_done) begin
        c_out = c;
        break;
      end
    end
  endtask

  task automatic wait_retry(output int c_out);
    c_out = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (rcvr_retry) begin
        c_out = c;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset holds everything at zero even with bus-off and auto recovery asserted.
    g_rst = 1'b1; bo_host = 1'b1; auto_en = 1'b1;
    sampled_bit = 1'b1; smpl_en = 1'b1;
    tick(); tick();
    chk("rst_init",  32'(init_err_st), 32'd0);
    chk("rst_busy",  32'(rcvr_busy),   32'd0);
    chk("rst_done",  32'(rcvr_done),   32'd0);
    chk("rst_retry", 32'(rcvr_retry),  32'd0);
    chk("rst_seq",   32'(seq_cnt),     32'd0);
    chk("rst_rcsv",  32'(rcsv_cnt),    32'd0);

    // T1: automatic recovery. The final run of 1408 recessive bits causes one pulse, followed by done.
    do_reset();
    auto_en = 1'b1; bo_host = 1'b1;
    tick();
    chk("t1_busy", 32'(rcvr_busy), 32'd1);
    n_init = 0;
    send_bits(1407, 1'b1);
    chk("t1_seq_pre",  32'(seq_cnt),  32'd127);
    chk("t1_rcsv_pre", 32'(rcsv_cnt), 32'd10);
    chk("t1_no_early", 32'(n_init),   32'd0);
    send_last_bit();
    chk("t1_init",     32'(init_err_st), 32'd1);
    chk("t1_seq_full", 32'(seq_cnt),     32'd128);
    wait_done(cyc, n_ext);
    chk("t1_done_lat", 32'(cyc),       32'd4);
    chk("t1_one_pls",  32'(n_ext),     32'd0);
    chk("t1_idle",     32'(rcvr_busy), 32'd0);
    chk("t1_seq_clr",  32'(seq_cnt),   32'd0);
    tick();
    chk("t1_done_1c",  32'(rcvr_done), 32'd0);

    // T2: a dominant bit restarts the run. After 11 more recessive bits, one sequence is complete.
    do_reset();
    auto_en = 1'b1; bo_host = 1'b1;
    tick();
    send_bits(10, 1'b1);
    chk("t2_rcsv10", 32'(rcsv_cnt), 32'd10);
    send_bits(1, 1'b0);
    chk("t2_rcsv0",  32'(rcsv_cnt), 32'd0);
    chk("t2_seq0",   32'(seq_cnt),  32'd0);
    send_bits(11, 1'b1);
    chk("t2_seq1",   32'(seq_cnt),  32'd1);
    chk("t2_rcsv_w", 32'(rcsv_cnt), 32'd0);

    // T3: manual mode. No counting happens until rcvr_req is seen in WAIT_REQ.
    do_reset();
    auto_en = 1'b0; bo_host = 1'b1;
    tick();
    n_init = 0;
    send_bits(2000, 1'b1);
    chk("t3_busy0", 32'(rcvr_busy), 32'd0);
    chk("t3_seq0",  32'(seq_cnt),   32'd0);
    chk("t3_rcsv0", 32'(rcsv_cnt),  32'd0);
    chk("t3_nopls", 32'(n_init),    32'd0);
    rcvr_req = 1'b1;
    tick();
    rcvr_req = 1'b0;
    chk("t3_busy1", 32'(rcvr_busy), 32'd1);
    send_bits(1407, 1'b1);
    chk("t3_no_early", 32'(n_init), 32'd0);
    send_last_bit();
    chk("t3_init", 32'(init_err_st), 32'd1);
    wait_done(cyc, n_ext);
    chk("t3_done_lat", 32'(cyc), 32'd4);

    // T4: the generator never clears bus-off, so the block retries after 7 WAIT_CLR cycles. The generator clears after that.
    do_reset();
    m_clr_en = 1'b0;
    auto_en = 1'b1; bo_host = 1'b1;
    tick();
    send_bits(1407, 1'b1);
    send_last_bit();
    chk("t4_init1", 32'(init_err_st), 32'd1);
    wait_retry(cyc);
    chk("t4_retry_lat", 32'(cyc),         32'd8);
    chk("t4_init2",     32'(init_err_st), 32'd1);
    m_clr_en = 1'b1;
    wait_done(cyc, n_ext);
    chk("t4_done_lat", 32'(cyc),   32'd4);
    chk("t4_no_extra", 32'(n_ext), 32'd0);
    n_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rcvr_done || init_err_st) n_cnt++;
    end
    chk("t4_done_once", 32'(n_cnt), 32'd0);

    // T5: an external clear at seq_cnt=60 wins over a coincident strobe. Reset at seq_cnt=100 then zeroes all outputs.
    do_reset();
    auto_en = 1'b1; bo_host = 1'b1;
    tick();
    n_init = 0;
    send_bits(660, 1'b1);
    chk("t5_seq60", 32'(seq_cnt), 32'd60);
    bo_host = 1'b0; sampled_bit = 1'b1; smpl_en = 1'b1;
    tick();
    smpl_en = 1'b0;
    chk("t5_clr_seq",  32'(seq_cnt),   32'd0);
    chk("t5_clr_rcsv", 32'(rcsv_cnt),  32'd0);
    chk("t5_clr_busy", 32'(rcvr_busy), 32'd0);
    chk("t5_clr_done", 32'(rcvr_done), 32'd0);
    bo_host = 1'b1;
    tick();
    send_bits(1100, 1'b1);
    send_bits(3, 1'b1);
    chk("t5_seq100",  32'(seq_cnt),  32'd100);
    chk("t5_rcsv3",   32'(rcsv_cnt), 32'd3);
    chk("t5_no_pls",  32'(n_init),   32'd0);
    g_rst = 1'b1;
    tick();
    chk("t5_rst_busy", 32'(rcvr_busy),   32'd0);
    chk("t5_rst_seq",  32'(seq_cnt),     32'd0);
    chk("t5_rst_rcsv", 32'(rcsv_cnt),    32'd0);
    chk("t5_rst_init", 32'(init_err_st), 32'd0);
    g_rst = 1'b0;

    // T6: rcvr_req held high beforehand does not pre-arm. It is taken on the first WAIT_REQ cycle.
    do_reset();
    auto_en = 1'b0; rcvr_req = 1'b1;
    tick(); tick();
    chk("t6_idle_busy", 32'(rcvr_busy), 32'd0);
    bo_host = 1'b1;
    tick();
    chk("t6_waitreq", 32'(rcvr_busy), 32'd0);
    tick();
    chk("t6_count",   32'(rcvr_busy), 32'd1);
    rcvr_req = 1'b0;

    // A rising edge on auto_rcvr_en in WAIT_REQ starts counting. Losing bus-off in WAIT_REQ returns to IDLE silently.
    do_reset();
    auto_en = 1'b0; bo_host = 1'b1;
    tick(); tick();
    chk("t6_wait_hold", 32'(rcvr_busy), 32'd0);
    auto_en = 1'b1;
    tick();
    chk("t6_auto_rise", 32'(rcvr_busy), 32'd1);
    do_reset();
    auto_en = 1'b0; bo_host = 1'b1;
    tick();
    bo_host = 1'b0;
    tick();
    chk("t6_wr_nodone", 32'(rcvr_done), 32'd0);
    bo_host = 1'b1; auto_en = 1'b1;
    tick();
    chk("t6_wr_idle_rearm", 32'(rcvr_busy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
